mc_main_control: RTL and testbench

//  Multi-cycle main control FSM for the MIPS datapath; sits directly upstream of the ALU control decoder.

---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/mc_main_control.sv | 180 ++++++++++++++++++
 tb/tb_mc_main_control.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcodes, ALUop
// codes consumed by ALU control, mux select codes and the FSM state type.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_OR    = 3'b010;
  localparam logic [2:0] ALUOP_RTYPE = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC     = 4'd3,
    ST_R_WB     = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_ADDI_EX  = 4'd11,
    ST_ORI_EX   = 4'd12,
    ST_IMM_WB   = 4'd13
  } state_e;

  // All datapath controls driven by the FSM, decoded together per state.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  // States that wait on the memory ready handshake.
  function automatic logic is_mem_wait(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory watchdog: counts consecutive stalled cycles and flags the cycle on
// which the MEM_TIMEOUT-th stall occurs. MEM_TIMEOUT=0 disables it.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clr,
  output logic expired
);

  localparam int          TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic        ENABLED = (MEM_TIMEOUT > 0);
  localparam logic [TW-1:0] LAST  = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [TW-1:0] cnt;

  // Expiry is combinational so the abort happens in the stall cycle itself.
  assign expired = ENABLED && count_en && (cnt == LAST);

  // Stall counter; cleared whenever the FSM changes state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !ENABLED) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback, stalls on mem_ready with a watchdog, counts retired instructions.
module mc_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic [2:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal_op,
  output logic                mem_err,
  output logic [RETIRE_W-1:0] retired,
  output logic [3:0]          state_dbg
);

  state_e state, state_next;
  logic   stall, expired, retire;
  ctrl_t  c;

  // zero is consumed by the datapath's PC-write gating, not by sequencing.
  logic unused_zero;
  assign unused_zero = zero;

  assign stall = is_mem_wait(state) && !mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (stall),
    .clr      (state_next != state),
    .expired  (expired)
  );

  // Next-state and retire decision; a watchdog expiry aborts to IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_next = state;
    retire     = 1'b0;
    case (state)
      ST_IDLE:     state_next = ST_FETCH;
      ST_FETCH:    if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next = ST_EXEC;
          OP_LW, OP_SW:  state_next = ST_MEM_ADDR;
          OP_BEQ:        state_next = ST_BRANCH;
          OP_J:          state_next = ST_JUMP;
          OP_ADDI:       state_next = ST_ADDI_EX;
          OP_ORI:        state_next = ST_ORI_EX;
          default:       state_next = ST_FETCH;
        endcase
      end
      ST_EXEC:     state_next = ST_R_WB;
      ST_MEM_ADDR: state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_next = ST_MEM_WB;
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_next = ST_FETCH;
          retire     = 1'b1;
        end
      end
      ST_ADDI_EX, ST_ORI_EX: state_next = ST_IMM_WB;
      ST_R_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP, ST_IMM_WB: begin
        state_next = ST_FETCH;
        retire     = 1'b1;
      end
      default:     state_next = ST_IDLE;
    endcase
    if (expired) begin
      state_next = ST_IDLE;
      retire     = 1'b0;
    end
  end

  // State register and retired-instruction counter (wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      retired <= '0;
    end else begin
      state <= state_next;
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Moore output decode; FETCH's IR/PC loads follow mem_ready directly.
  always_comb begin
    c = '0;
    case (state)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      ST_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
      ST_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_ORI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_OR;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = !expired;
        c.iord      = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      ST_IMM_WB:   c.reg_write = 1'b1;
      default:     c = '0;
    endcase
  end

  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign iord          = c.iord;
  assign ir_write      = c.ir_write;
  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign pc_source     = c.pc_source;
  assign alu_op        = c.alu_op;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign reg_write     = c.reg_write;
  assign reg_dst       = c.reg_dst;
  assign mem_to_reg    = c.mem_to_reg;
  assign illegal_op    = (state == ST_DECODE) && !is_legal_op(opcode);
  assign mem_err       = expired;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: directed scenarios plus random
// instruction streams checked against per-instruction expectations
// (latency, write/enable counts, ALUop, retire count).
module tb_mc_main_control;
  import mc_ctrl_pkg::*;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          zero, mem_ready;
  logic          mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_source, alu_src_b;
  logic [2:0]    alu_op;
  logic          alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op, mem_err;
  logic [RW-1:0] retired;
  logic [3:0]    state_dbg;
  logic [18:0]   all_outs;

  int n_tests, n_fail, exp_ret;

  state_e lw_seq [6] = '{ST_IDLE, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB};

  mc_main_control #(.MEM_TIMEOUT(16), .RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .mem_err(mem_err), .retired(retired), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign all_outs = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                     alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg,
                     illegal_op, mem_err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting at the negedge of its FETCH cycle and
  // returns at the negedge of the next FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fstall, input int mstall);
    int cyc, wcnt, target, n_irw, n_pcw, n_pcc, n_rw, n_mw, n_mr, n_ill, n_err, n_ex;
    int exp_cyc, exp_mr, exp_mw, exp_rw;
    logic [3:0] last_st;
    logic [2:0] ex_op, exp_ex;
    logic [1:0] br_src, j_src;
    logic wb_dst, wb_m2r, left;
    bit legal, is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_ori;
    cyc = 0; wcnt = 0; left = 1'b0; last_st = state_dbg;
    n_irw = 0; n_pcw = 0; n_pcc = 0; n_rw = 0; n_mw = 0; n_mr = 0; n_ill = 0; n_err = 0; n_ex = 0;
    ex_op = '0; br_src = '0; j_src = '0; wb_dst = 1'b0; wb_m2r = 1'b0;
    opcode = op;
    while (1) begin
      if (state_dbg != last_st) wcnt = 0;
      last_st = state_dbg;
      target = (state_dbg == ST_FETCH) ? fstall : mstall;
      if (state_dbg inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) mem_ready = (wcnt >= target);
      else mem_ready = 1'($urandom_range(0, 1));
      zero = z;
      #1;
      n_irw += int'(ir_write);
      n_pcw += int'(pc_write);
      n_pcc += int'(pc_write_cond);
      n_mr  += int'(mem_read);
      n_mw  += int'(mem_write);
      n_ill += int'(illegal_op);
      n_err += int'(mem_err);
      if (alu_src_a) begin n_ex++; ex_op = alu_op; end
      if (reg_write) begin n_rw++; wb_dst = reg_dst; wb_m2r = mem_to_reg; end
      if (pc_write_cond) br_src = pc_source;
      if (pc_write && !ir_write) j_src = pc_source;
      if (state_dbg != ST_FETCH) left = 1'b1;
      wcnt++; cyc++;
      @(negedge clk);
      if ((left && state_dbg == ST_FETCH) || cyc >= 64) break;
    end
    is_r = (op == OP_RTYPE); is_lw = (op == OP_LW); is_sw = (op == OP_SW);
    is_beq = (op == OP_BEQ); is_j = (op == OP_J); is_addi = (op == OP_ADDI); is_ori = (op == OP_ORI);
    legal = is_r || is_lw || is_sw || is_beq || is_j || is_addi || is_ori;
    if (is_lw) exp_cyc = 5;
    else if (is_r || is_sw || is_addi || is_ori) exp_cyc = 4;
    else if (is_beq || is_j) exp_cyc = 3;
    else exp_cyc = 2;
    exp_cyc += fstall + ((is_lw || is_sw) ? mstall : 0);
    exp_mr = fstall + 1 + (is_lw ? mstall + 1 : 0);
    exp_mw = is_sw ? mstall + 1 : 0;
    exp_rw = (is_r || is_lw || is_addi || is_ori) ? 1 : 0;
    if (legal) exp_ret = (exp_ret + 1) % (1 << RW);
    check($sformatf("latency op=%b", op), cyc, exp_cyc);
    check("ir_write_cycles", n_irw, 1);
    check("pc_write_cycles", n_pcw, is_j ? 2 : 1);
    check("pc_write_cond_cycles", n_pcc, is_beq ? 1 : 0);
    check("mem_read_cycles", n_mr, exp_mr);
    check("mem_write_cycles", n_mw, exp_mw);
    check("reg_write_cycles", n_rw, exp_rw);
    check("illegal_pulses", n_ill, legal ? 0 : 1);
    check("mem_err_pulses", n_err, 0);
    check("exec_cycles", n_ex, (legal && !is_j) ? 1 : 0);
    check("retired", retired, exp_ret);
    if (legal && !is_j) begin
      if (is_r) exp_ex = ALUOP_RTYPE;
      else if (is_beq) exp_ex = ALUOP_SUB;
      else if (is_ori) exp_ex = ALUOP_OR;
      else exp_ex = ALUOP_ADD;
      check("exec_alu_op", ex_op, exp_ex);
    end
    if (exp_rw == 1) begin
      check("wb_reg_dst", wb_dst, is_r ? 1 : 0);
      check("wb_mem_to_reg", wb_m2r, is_lw ? 1 : 0);
    end
    if (is_beq) check("beq_pc_source", br_src, PCSRC_ALUOUT);
    if (is_j) check("j_pc_source", j_src, PCSRC_JUMP);
  endtask

  initial begin
    int k;
    logic mw_at_err;
    logic [5:0] op;
    n_tests = 0; n_fail = 0; exp_ret = 0;
    rst_n = 1'b0; opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", state_dbg, ST_IDLE);
    check("reset_outputs", all_outs, 0);
    check("reset_retired", retired, 0);

    // Directed lw with mem_ready tied high
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("lw_state_%0d", i), state_dbg, lw_seq[i]);
      if (lw_seq[i] == ST_IDLE) check("idle_outputs", all_outs, 0);
      if (lw_seq[i] == ST_MEM_ADDR) check("lw_addr_alu_op", alu_op, ALUOP_ADD);
      if (lw_seq[i] == ST_MEM_WB) check("lw_retired_before", retired, 0);
      @(negedge clk);
    end
    exp_ret = 1;
    check("lw_back_to_fetch", state_dbg, ST_FETCH);
    check("lw_retired_after", retired, exp_ret);

    // Directed: R-type and beq both ways
    run_instr(OP_RTYPE, 1'b0, 0, 0);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);

    // FETCH with mem_ready low for three cycles (j instruction)
    opcode = OP_J;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check($sformatf("fetch_stall_ir_write_%0d", i), ir_write, (i == 3) ? 1 : 0);
      check($sformatf("fetch_stall_pc_write_%0d", i), pc_write, (i == 3) ? 1 : 0);
      check($sformatf("fetch_stall_mem_err_%0d", i), mem_err, 0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    exp_ret = (exp_ret + 1) % (1 << RW);
    check("fetch_stall_j_done", state_dbg, ST_FETCH);
    check("fetch_stall_j_retired", retired, exp_ret);

    // Illegal opcode 111111
    opcode = 6'b111111;
    @(negedge clk);
    #1;
    check("illegal_in_decode", illegal_op, 1);
    @(negedge clk);
    #1;
    check("illegal_return_fetch", state_dbg, ST_FETCH);
    check("illegal_pulse_one_cycle", illegal_op, 0);
    check("illegal_no_retire", retired, exp_ret);
    @(negedge clk);
    #1;
    check("illegal_decode_again", state_dbg, ST_DECODE);
    opcode = OP_ADDI;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    exp_ret = (exp_ret + 1) % (1 << RW);
    check("addi_after_illegal_fetch", state_dbg, ST_FETCH);
    check("addi_after_illegal_retired", retired, exp_ret);

    // Random instruction stream, including stalls of exactly 15 (ready wins)
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        6: op = OP_ORI;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, 1'($urandom_range(0, 1)),
                (i % 9 == 4) ? 15 : int'($urandom_range(0, 4)),
                (i % 5 == 2) ? 15 : int'($urandom_range(0, 4)));
    end

    // Watchdog: sw with mem_ready stuck low in MEM_WR
    opcode = OP_SW; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("wd_in_mem_wr", state_dbg, ST_MEM_WR);
    k = 0; mw_at_err = 1'b1;
    while (k < 40) begin
      mem_ready = 1'b0;
      k++;
      if (k > 1) #1;
      if (mem_err) begin
        mw_at_err = mem_write;
        break;
      end
      @(negedge clk);
    end
    check("wd_expiry_cycle", k, 16);
    check("wd_no_write_on_err", mw_at_err, 0);
    @(negedge clk);
    #1;
    check("wd_state_idle", state_dbg, ST_IDLE);
    check("wd_outputs_zero", all_outs, 0);
    check("wd_retired_unchanged", retired, exp_ret);
    mem_ready = 1'b1;
    @(negedge clk);
    check("wd_restart_fetch", state_dbg, ST_FETCH);

    // Reset asserted mid MEM_RD
    opcode = OP_LW;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("rst_mid_in_mem_rd", state_dbg, ST_MEM_RD);
    check("rst_mid_mem_read", mem_read, 1);
    #2;
    rst_n = 1'b0;
    exp_ret = 0;
    #1;
    check("rst_mid_state", state_dbg, ST_IDLE);
    check("rst_mid_outputs", all_outs, 0);
    check("rst_mid_retired", retired, exp_ret);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold_outputs", all_outs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_fetch", state_dbg, ST_FETCH);
    run_instr(OP_ORI, 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
